// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and
// writeback-control bit positions.
package mem_pkg;

    // Access size encodings carried on ex_size
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Memory-latency FSM states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Bit positions inside the 2-bit writeback control field
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/data_mem_be.sv
// Byte-enabled data RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module data_mem_be #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [XLEN/8-1:0]              be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [XLEN-1:0]                wdata,
    output logic [XLEN-1:0]                rdata
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] ram [DEPTH_WORDS];

    // Write only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = ram[idx];

endmodule

// File: rtl/mem_stage_p.sv
// MEM stage: branch resolve, sized loads/stores against a byte-enabled RAM,
// configurable wait-state latency with upstream stall, and the MEM/WB register.
module mem_stage_p
    import mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 1,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic [1:0]       ex_size,
    input  logic             ex_unsigned,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic [XLEN-1:0]  ex_addr,
    input  logic [XLEN-1:0]  ex_wdata,
    input  logic [1:0]       ex_wb,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             flush,
    output logic             pc_src,
    output logic             mem_stall,
    output logic             wb_valid,
    output logic [1:0]       wb_ctrl,
    output logic [XLEN-1:0]  wb_alu,
    output logic [XLEN-1:0]  wb_load,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_misalign
);

    localparam int         NB    = XLEN / 8;
    localparam int         OFF_W = $clog2(NB);
    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT   = 4'(MEM_LATENCY);

    // Alignment rule; dword never fits a 32-bit datapath
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return (XLEN == 32) ? 1'b1 : |off;
        endcase
    endfunction

    // Lane enables: a contiguous run of 2^sz bytes starting at the byte offset
    function automatic logic [NB-1:0] byte_en(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        int            nbytes;
        logic [NB-1:0] m;
        nbytes = 1 << sz;
        m      = (nbytes >= NB) ? '1 : NB'((1 << nbytes) - 1);
        return m << off;
    endfunction

    // Replicate the low store bytes so every candidate lane carries them
    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] sz, input logic [XLEN-1:0] wd);
        case (sz)
            SZ_B:    return {NB{wd[7:0]}};
            SZ_H:    return {(NB/2){wd[15:0]}};
            SZ_W:    return {(XLEN/32){wd[31:0]}};
            default: return wd;
        endcase
    endfunction

    // Shift the addressed lanes down, then sign- or zero-extend to XLEN
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw, input logic [OFF_W-1:0] off,
                                                 input logic [1:0] sz, input logic uns);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] mask;
        int              nbits;
        logic            sgn;
        sh    = raw >> (8 * int'(off));
        nbits = 8 << sz;
        mask  = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        sgn   = ~uns & (|(sh & (XLEN'(1) << (nbits - 1))));
        return sgn ? (sh | ~mask) : (sh & mask);
    endfunction

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wb_valid_q, wb_valid_d;
    logic [1:0]       wb_ctrl_q, wb_ctrl_d;
    logic [XLEN-1:0]  wb_alu_q, wb_alu_d;
    logic [XLEN-1:0]  wb_load_q, wb_load_d;
    logic [REG_W-1:0] wb_dest_q, wb_dest_d;
    logic             wb_misalign_q, wb_misalign_d;
    logic             capture;

    logic             mem_op, mis_op, aligned_op, is_load;
    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  rdata;
    logic             mem_we;

    assign pc_src     = ex_valid & ex_branch & ex_zero;
    assign mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
    assign off        = ex_addr[OFF_W-1:0];
    assign idx        = ex_addr[OFF_W +: IDX_W];
    assign mis_op     = mem_op & is_misaligned(ex_size, off);
    assign aligned_op = mem_op & ~mis_op;
    // Read+write together behaves as a store
    assign is_load    = aligned_op & ex_mem_read & ~ex_mem_write;

    // Stall is dropped while flushing so upstream does not replay the killed op
    assign mem_stall = ~rst & ~flush &
                       (((state_q == S_IDLE) & aligned_op & (LAT != 4'd0)) |
                        ((state_q == S_WAIT) & (cnt_q != LAT)));

    // Commit a store only on the capturing (completing) cycle
    assign mem_we = capture & aligned_op & ex_mem_write & ~rst;

    data_mem_be #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (byte_en(ex_size, off)),
        .idx   (idx),
        .wdata (lane_wdata(ex_size, ex_wdata)),
        .rdata (rdata)
    );

    // Latency FSM and MEM/WB next-state; flush beats capture
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wb_valid_d    = wb_valid_q;
        wb_ctrl_d     = wb_ctrl_q;
        wb_alu_d      = wb_alu_q;
        wb_load_d     = wb_load_q;
        wb_dest_d     = wb_dest_q;
        wb_misalign_d = wb_misalign_q;
        capture       = 1'b0;
        if (flush) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            wb_valid_d    = 1'b0;
            wb_ctrl_d     = '0;
            wb_misalign_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (aligned_op && (LAT != 4'd0)) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end else begin
                        capture = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == LAT) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        capture = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (capture) begin
            wb_valid_d             = ex_valid;
            wb_ctrl_d[WB_REGWRITE] = ex_valid & ~mis_op & ex_wb[WB_REGWRITE];
            wb_ctrl_d[WB_MEMTOREG] = ex_valid & ~mis_op & ex_wb[WB_MEMTOREG];
            wb_alu_d               = ex_addr;
            wb_load_d              = is_load ? load_ext(rdata, off, ex_size, ex_unsigned) : '0;
            wb_dest_d              = ex_dest;
            wb_misalign_d          = mis_op;
        end
    end

    // State and MEM/WB register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_ctrl_q     <= '0;
            wb_alu_q      <= '0;
            wb_load_q     <= '0;
            wb_dest_q     <= '0;
            wb_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_valid_q    <= wb_valid_d;
            wb_ctrl_q     <= wb_ctrl_d;
            wb_alu_q      <= wb_alu_d;
            wb_load_q     <= wb_load_d;
            wb_dest_q     <= wb_dest_d;
            wb_misalign_q <= wb_misalign_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_ctrl     = wb_ctrl_q;
    assign wb_alu      = wb_alu_q;
    assign wb_load     = wb_load_q;
    assign wb_dest     = wb_dest_q;
    assign wb_misalign = wb_misalign_q;

    // Upstream protocol: no simultaneous read+write, inputs held while stalled
    a_rw_excl: assert property (@(posedge clk) disable iff (rst)
        ex_valid |-> !(ex_mem_read && ex_mem_write));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        mem_stall |=> ($stable(ex_valid) && $stable(ex_mem_read) && $stable(ex_mem_write) &&
                       $stable(ex_size) && $stable(ex_unsigned) && $stable(ex_addr) &&
                       $stable(ex_wdata)));

endmodule

// File: tb/tb_mem_stage_p.sv
// Bench for mem_stage_p: three instances (latency 0, 2, 3) share data inputs
// and each has its own ex_valid; a byte-addressed memory model predicts results.
module tb_mem_stage_p;

    logic        clk, rst, flush;
    logic [2:0]  vld;
    logic        rd, wr, uns, br, zr;
    logic [1:0]  sz, wb;
    logic [31:0] addr, wdata;
    logic [4:0]  dest;

    logic        pc_a [3];
    logic        stall_a [3];
    logic        wbv_a [3];
    logic [1:0]  ctrl_a [3];
    logic [31:0] alu_a [3];
    logic [31:0] load_a [3];
    logic [4:0]  dest_a [3];
    logic        mis_a [3];

    logic [7:0]  rmem [3][1024];
    int          n_checks = 0;
    int          n_err = 0;

    mem_stage_p #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LATENCY(0), .REG_W(5)) u_l0 (
        .clk(clk), .rst(rst), .ex_valid(vld[0]), .ex_mem_read(rd), .ex_mem_write(wr),
        .ex_size(sz), .ex_unsigned(uns), .ex_branch(br), .ex_zero(zr), .ex_addr(addr),
        .ex_wdata(wdata), .ex_wb(wb), .ex_dest(dest), .flush(flush), .pc_src(pc_a[0]),
        .mem_stall(stall_a[0]), .wb_valid(wbv_a[0]), .wb_ctrl(ctrl_a[0]), .wb_alu(alu_a[0]),
        .wb_load(load_a[0]), .wb_dest(dest_a[0]), .wb_misalign(mis_a[0]));

    mem_stage_p #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LATENCY(2), .REG_W(5)) u_l2 (
        .clk(clk), .rst(rst), .ex_valid(vld[1]), .ex_mem_read(rd), .ex_mem_write(wr),
        .ex_size(sz), .ex_unsigned(uns), .ex_branch(br), .ex_zero(zr), .ex_addr(addr),
        .ex_wdata(wdata), .ex_wb(wb), .ex_dest(dest), .flush(flush), .pc_src(pc_a[1]),
        .mem_stall(stall_a[1]), .wb_valid(wbv_a[1]), .wb_ctrl(ctrl_a[1]), .wb_alu(alu_a[1]),
        .wb_load(load_a[1]), .wb_dest(dest_a[1]), .wb_misalign(mis_a[1]));

    mem_stage_p #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LATENCY(3), .REG_W(5)) u_l3 (
        .clk(clk), .rst(rst), .ex_valid(vld[2]), .ex_mem_read(rd), .ex_mem_write(wr),
        .ex_size(sz), .ex_unsigned(uns), .ex_branch(br), .ex_zero(zr), .ex_addr(addr),
        .ex_wdata(wdata), .ex_wb(wb), .ex_dest(dest), .flush(flush), .pc_src(pc_a[2]),
        .mem_stall(stall_a[2]), .wb_valid(wbv_a[2]), .wb_ctrl(ctrl_a[2]), .wb_alu(alu_a[2]),
        .wb_load(load_a[2]), .wb_dest(dest_a[2]), .wb_misalign(mis_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: alignment from access size and address
    function automatic bit model_mis(input logic [1:0] s, input logic [31:0] a);
        case (s)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    // Reference load: little-endian bytes from a 1 KiB wrapping byte memory
    function automatic logic [31:0] model_load(input int k, input logic [1:0] s, input bit u, input logic [31:0] a);
        int          n;
        logic [31:0] v;
        n = 1 << s;
        v = 0;
        for (int b = 0; b < n; b++) v |= 32'(rmem[k][(int'(a[9:0]) + b) % 1024]) << (8 * b);
        if (!u && n < 4 && (((v >> (8 * n - 1)) & 32'd1) != 0)) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    task automatic model_store(input int k, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 1 << s;
        for (int b = 0; b < n; b++) rmem[k][(int'(a[9:0]) + b) % 1024] = 8'(d >> (8 * b));
    endtask

    // One load (w=0) or store (w=1) on instance k, checked against the model
    task automatic op(input int k, input bit w, input logic [1:0] s, input bit u,
                      input logic [31:0] a, input logic [31:0] d);
        int          stalls, lat_exp;
        bit          done, m;
        logic [31:0] exp_ld;
        logic [1:0]  wbv;
        logic [4:0]  dv;
        wbv     = 2'($urandom);
        dv      = 5'($urandom);
        m       = model_mis(s, a);
        lat_exp = m ? 0 : lat_of(k);
        @(negedge clk);
        vld = 3'b001 << k; rd = ~w; wr = w; sz = s; uns = u; addr = a; wdata = d;
        wb = wbv; dest = dv; br = 1'b0; zr = 1'b0;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall_a[k]) begin
                chk("no_early_capture", 64'(wbv_a[k]), 64'd0);
                stalls++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        chk("stall_bound", 64'(done), 64'd1);
        chk("stall_cycles", 64'(stalls), 64'(lat_exp));
        @(negedge clk);
        exp_ld = (!w && !m) ? model_load(k, s, u, a) : 32'd0;
        chk("wb_valid", 64'(wbv_a[k]), 64'd1);
        chk("wb_ctrl", 64'(ctrl_a[k]), m ? 64'd0 : 64'(wbv));
        chk("wb_alu", 64'(alu_a[k]), 64'(a));
        chk("wb_load", 64'(load_a[k]), 64'(exp_ld));
        chk("wb_dest", 64'(dest_a[k]), 64'(dv));
        chk("wb_misalign", 64'(mis_a[k]), 64'(m));
        if (w && !m) model_store(k, s, a, d);
        vld = 3'b000; rd = 1'b0; wr = 1'b0;
    endtask

    // A valid non-memory op so MEM/WB holds non-zero contents
    task automatic alu_op(input int k, input logic [31:0] a);
        @(negedge clk);
        vld = 3'b001 << k; rd = 1'b0; wr = 1'b0; addr = a; wb = 2'b11; dest = 5'd7;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; vld = '0; rd = 0; wr = 0; uns = 0; br = 0; zr = 0;
        sz = 2'd0; wb = 2'd0; addr = '0; wdata = '0; dest = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_wb_valid", 64'(wbv_a[k]), 64'd0);
            chk("rst_wb_alu", 64'(alu_a[k]), 64'd0);
            chk("rst_stall", 64'(stall_a[k]), 64'd0);
        end

        // Zero latency: word store then load, no stall
        op(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("l0_word_load", 64'(load_a[0]), 64'hDEAD_BEEF);

        // Latency 3: signed / unsigned byte loads
        op(2, 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_1234);
        op(2, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        chk("lb_signed", 64'(load_a[2]), 64'hFFFF_FF80);
        op(2, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        chk("lb_unsigned", 64'(load_a[2]), 64'h0000_0080);

        // Half store over a word, then a misaligned half load
        op(2, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
        op(2, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_ABCD);
        op(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("sh_merge", 64'(load_a[2]), 64'hABCD_3344);
        op(2, 1'b0, 2'd1, 1'b0, 32'h21, 32'h0);
        chk("lh_misalign", 64'(mis_a[2]), 64'd1);

        // Latency 2: flush in the second stall cycle drops the store
        op(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h5555_AAAA);
        alu_op(1, 32'h0000_CAFE);
        @(negedge clk);
        vld = 3'b010; rd = 0; wr = 1; sz = 2'd2; addr = 32'h40; wdata = 32'h1234_5678;
        #1 chk("flush_stall1", 64'(stall_a[1]), 64'd1);
        @(negedge clk);
        #1 chk("flush_stall2", 64'(stall_a[1]), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wb_valid", 64'(wbv_a[1]), 64'd0);
        flush = 1'b0; vld = '0; wr = 0;
        op(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        chk("flush_mem_kept", 64'(load_a[1]), 64'h5555_AAAA);

        // Same scenario with reset
        alu_op(1, 32'h0000_CAFE);
        @(negedge clk);
        vld = 3'b010; rd = 0; wr = 1; sz = 2'd2; addr = 32'h40; wdata = 32'h1234_5678;
        @(negedge clk);
        #1 chk("rst_mid_stall", 64'(stall_a[1]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld = '0; wr = 0;
        #1;
        chk("rstw_valid", 64'(wbv_a[1]), 64'd0);
        chk("rstw_ctrl", 64'(ctrl_a[1]), 64'd0);
        chk("rstw_alu", 64'(alu_a[1]), 64'd0);
        chk("rstw_load", 64'(load_a[1]), 64'd0);
        chk("rstw_dest", 64'(dest_a[1]), 64'd0);
        chk("rstw_mis", 64'(mis_a[1]), 64'd0);
        chk("rstw_stall", 64'(stall_a[1]), 64'd0);
        op(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        chk("rst_mem_kept", 64'(load_a[1]), 64'h5555_AAAA);

        // Branch resolve over all valid/branch/zero combinations
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vld = {2'b00, i[0]}; br = i[1]; zr = i[2]; rd = 0; wr = 0;
            #1 chk("pc_src", 64'(pc_a[0]), 64'(i == 7));
        end
        @(negedge clk);
        vld = '0; br = 0; zr = 0;

        // Word index wraps modulo depth
        op(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hA5A5_0F0F);
        op(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        chk("alias_word0", 64'(load_a[0]), 64'hA5A5_0F0F);

        // Randomized traffic over a pre-filled window, with aliased addresses
        for (int k = 0; k < 3; k += 2)
            for (int i = 0; i < 16; i++) op(k, 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);
        for (int i = 0; i < 60; i++)
            op(0, 1'($urandom), 2'($urandom), 1'($urandom),
               32'($urandom_range(0, 63)) + 32'(1024 * $urandom_range(0, 3)), $urandom);
        for (int i = 0; i < 25; i++)
            op(2, 1'($urandom), 2'($urandom), 1'($urandom),
               32'($urandom_range(0, 63)) + 32'(1024 * $urandom_range(0, 3)), $urandom);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
